spi_receiver: RTL

//   SPI slave/receiver end of the SPI interface: the counterpart of the SPI transmitter driving SCK/CS/MOSI.

---
 rtl/spi_receiver_if.sv | 21 ++
 rtl/spi_receiver.sv | 135 +++++++++++++
 2 files changed

// File: rtl/spi_receiver_if.sv
// SPI pin bundle between a transmitter (master) and the receiver (slave).
interface spi_receiver_if;
  logic SCK;
  logic CS;
  logic MOSI;
  logic MISO;

  modport master (
    output SCK,
    output CS,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SCK,
    input  CS,
    input  MOSI,
    output MISO
  );
endinterface

// File: rtl/spi_receiver.sv
// SPI receiver: oversamples SCK/CS/MOSI, assembles MSB-first words, replies on MISO.
// Optional macro SPI_RX_OVERRUN_EN enables the sticky overrun flag.
module spi_receiver #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CKP,
  input  logic                  CPH,
  spi_receiver_if.slave         spi,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   ckp_q, cph_q;
  logic [DATA_WIDTH-1:0]  tx_shift_q, rx_shift_q, rx_data_q;
  logic [CntW-1:0]        cnt_q;
  logic                   done_q, miso_q, rx_valid_q, overrun_q;

  logic sck_s, cs_s, mosi_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise, overrun_set;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign lead_edge   = (sck_prev_q == ckp_q) && (sck_s != ckp_q);
  assign trail_edge  = (sck_prev_q != ckp_q) && (sck_s == ckp_q);
  assign sample_edge = cph_q ? trail_edge : lead_edge;
  assign shift_edge  = cph_q ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;

`ifdef SPI_RX_OVERRUN_EN
  assign overrun_set = done_q & rx_valid_q & ~rx_ack;
`else
  assign overrun_set = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sck_sync_q  <= {SYNC_STAGES{CKP}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sck_prev_q  <= CKP;
      cs_prev_q   <= 1'b1;
      ckp_q       <= CKP;
      cph_q       <= CPH;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi.SCK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      done_q      <= 1'b0;

      // Completion wins over a same-cycle ack, so rx_valid stays set.
      if (rx_ack) rx_valid_q <= 1'b0;
      if (rx_ack && !overrun_set) overrun_q <= 1'b0;
      if (done_q) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end
      if (overrun_set) overrun_q <= 1'b1;

      if (cs_rise) begin
        state_q <= StIdle;
        miso_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            ckp_q <= CKP;
            cph_q <= CPH;
            if (cs_fall) state_q <= StLoad;
          end
          StLoad: begin
            // tx_shift holds the bits not yet driven; CPH=1 re-drives the MSB on the first
            // leading edge, so it keeps the MSB in place.
            tx_shift_q <= cph_q ? data_in : (data_in << 1);
            miso_q     <= data_in[DATA_WIDTH-1];
            cnt_q      <= '0;
            state_q    <= StShift;
          end
          StShift: begin
            if (done_q) begin
              cnt_q      <= '0;
              tx_shift_q <= data_in;
            end
            if (sample_edge) begin
              rx_shift_q <= {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
              cnt_q      <= cnt_q + 1'b1;
              if (cnt_q == LastCnt) done_q <= 1'b1;
            end
            if (shift_edge) begin
              miso_q     <= tx_shift_q[DATA_WIDTH-1];
              tx_shift_q <= tx_shift_q << 1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign spi.MISO = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != StIdle);
  assign overrun  = overrun_q;

endmodule
